// File: rtl/cargador_programa_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = loader side (consumes bytes, drives the memory write).
interface cargador_programa_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_dato;
    logic              rx_valido;
    logic              mem_escribir;
    logic [ADDR_W-1:0] mem_direccion;
    logic [31:0]       mem_dato;

    modport master (
        input  rx_dato, rx_valido,
        output mem_escribir, mem_direccion, mem_dato
    );

    modport slave (
        output rx_dato, rx_valido,
        input  mem_escribir, mem_direccion, mem_dato
    );
endinterface

// File: rtl/cargador_programa.sv
// Program loader: parses A5/len/data/chk frames, writes big-endian words into
// instruction memory, holds the CPU while loading and reports checksum/length/timeout errors.
module cargador_programa #(
    parameter int         ADDR_W      = 10,
    parameter logic [7:0] START_BYTE  = 8'hA5,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              reset,
    cargador_programa_if.master bus,
    output logic              cpu_detener,
    output logic              carga_lista,
    output logic              error,
    output logic [1:0]        codigo_error,
    output logic [ADDR_W:0]   palabras
);
    localparam int               CNT_W     = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_FIN   = CNT_W'(TIMEOUT_CYC - 2);
    localparam logic [CNT_W-1:0] CNT_UNO   = CNT_W'(1);
    localparam logic [16:0]      CAPACIDAD = 17'(1 << ADDR_W);
    localparam logic [ADDR_W:0]  PAL_UNO   = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATOS, CHECK, LISTO, ERROR} estado_t;

    estado_t          estado, estado_sig;
    logic [7:0]       len_hi;
    logic [15:0]      longitud;
    logic [7:0]       checksum;
    logic [23:0]      ensamble;
    logic [1:0]       byte_idx;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       codigo_sig;
    logic [15:0]      n_rx;
    logic             inicio, expira, ultima, activo;

    assign inicio = bus.rx_valido && (bus.rx_dato == START_BYTE);
    // A byte arriving on the expiry cycle is consumed instead of timing out.
    assign expira = !bus.rx_valido && (cnt == CNT_FIN);
    assign n_rx   = {len_hi, bus.rx_dato};
    assign ultima = (17'(palabras) + 17'd1) == {1'b0, longitud};
    assign activo = estado inside {LEN_HI, LEN_LO, DATOS, CHECK};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado <= IDLE;
        else       estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        codigo_sig = 2'b00;
        case (estado)
            IDLE, LISTO, ERROR: if (inicio) estado_sig = LEN_HI;
            LEN_HI: if (bus.rx_valido) estado_sig = LEN_LO;
            LEN_LO: if (bus.rx_valido) begin
                if ({1'b0, n_rx} > CAPACIDAD) begin
                    estado_sig = ERROR;
                    codigo_sig = 2'b01;
                end else if (n_rx == 16'd0) begin
                    estado_sig = CHECK;
                end else begin
                    estado_sig = DATOS;
                end
            end
            DATOS: if (bus.rx_valido && byte_idx == 2'd3 && ultima) estado_sig = CHECK;
            CHECK: if (bus.rx_valido) begin
                if (bus.rx_dato == checksum) begin
                    estado_sig = LISTO;
                end else begin
                    estado_sig = ERROR;
                    codigo_sig = 2'b10;
                end
            end
            default: estado_sig = IDLE;
        endcase
        if (activo && expira) begin
            estado_sig = ERROR;
            codigo_sig = 2'b11;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_escribir  <= 1'b0;
            bus.mem_direccion <= '0;
            bus.mem_dato      <= '0;
            cpu_detener       <= 1'b0;
            carga_lista       <= 1'b0;
            error             <= 1'b0;
            codigo_error      <= 2'b00;
            palabras          <= '0;
            len_hi            <= '0;
            longitud          <= '0;
            checksum          <= '0;
            ensamble          <= '0;
            byte_idx          <= '0;
            cnt               <= '0;
        end else begin
            bus.mem_escribir <= 1'b0;
            cnt <= (activo && !bus.rx_valido) ? cnt + CNT_UNO : '0;
            case (estado)
                IDLE, LISTO, ERROR: if (inicio) begin
                    cpu_detener  <= 1'b1;
                    carga_lista  <= 1'b0;
                    error        <= 1'b0;
                    codigo_error <= 2'b00;
                    palabras     <= '0;
                    checksum     <= '0;
                    byte_idx     <= '0;
                end
                LEN_HI: if (bus.rx_valido) len_hi <= bus.rx_dato;
                LEN_LO: if (bus.rx_valido) longitud <= n_rx;
                DATOS: if (bus.rx_valido) begin
                    ensamble <= {ensamble[15:0], bus.rx_dato};
                    checksum <= checksum ^ bus.rx_dato;
                    byte_idx <= byte_idx + 2'd1;
                    // Word complete: registered write pulse, so back-to-back words never collide.
                    if (byte_idx == 2'd3) begin
                        bus.mem_escribir  <= 1'b1;
                        bus.mem_dato      <= {ensamble, bus.rx_dato};
                        bus.mem_direccion <= palabras[ADDR_W-1:0];
                        palabras          <= palabras + PAL_UNO;
                    end
                end
                CHECK: if (bus.rx_valido && bus.rx_dato == checksum) begin
                    carga_lista <= 1'b1;
                    cpu_detener <= 1'b0;
                end
                default: ;
            endcase
            if (estado_sig == ERROR && estado != ERROR) begin
                error        <= 1'b1;
                codigo_error <= codigo_sig;
            end
        end
    end
endmodule

// File: tb/tb_cargador_programa.sv
// Bench for cargador_programa: directed frames plus random frames checked
// against a frame-level model (parse header, rebuild words, XOR the data bytes).
module tb_cargador_programa;
    localparam int ADDR_W = 10;
    localparam int TO     = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             cpu_detener, carga_lista, error;
    logic [1:0]       codigo_error;
    logic [ADDR_W:0]  palabras;
    int               errores = 0;
    int               checks  = 0;
    int               ciclo_n = 0;

    typedef struct { int stamp; int dir; logic [31:0] dato; } esc_t;
    esc_t capt[$];

    cargador_programa_if #(.ADDR_W(ADDR_W)) bus ();

    cargador_programa #(.ADDR_W(ADDR_W), .START_BYTE(8'hA5), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.master),
        .cpu_detener  (cpu_detener),
        .carga_lista  (carga_lista),
        .error        (error),
        .codigo_error (codigo_error),
        .palabras     (palabras)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ciclo_n <= ciclo_n + 1;
    // Every cycle the write strobe is high is logged; a stretched pulse shows up as an extra entry.
    always @(negedge clk)
        if (bus.mem_escribir === 1'b1)
            capt.push_back('{ciclo_n, int'(bus.mem_direccion), bus.mem_dato});

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            errores++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, esp);
        end
    endtask

    task automatic enviar(input logic [7:0] b, input int hueco, output int stamp);
        repeat (hueco) begin @(posedge clk); #1; end
        bus.rx_dato   = b;
        bus.rx_valido = 1'b1;
        @(posedge clk); #1;
        stamp         = ciclo_n;
        bus.rx_valido = 1'b0;
    endtask

    task automatic huecos_rand(input int len, input int hmax, output int h[$]);
        h = {};
        for (int i = 0; i < len; i++) h.push_back(int'($urandom_range(hmax, 0)));
    endtask

    task automatic generar(input int n, input bit mal, output logic [7:0] q[$]);
        logic [7:0] x, b;
        x = 8'h00;
        q = {8'hA5, n[15:8], n[7:0]};
        if (n <= (1 << ADDR_W)) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                q.push_back(b);
                x ^= b;
            end
            if (mal) x ^= 8'($urandom_range(255, 1));
            q.push_back(x);
        end
    endtask

    // Sends a whole frame and checks writes and final status against the frame-level model.
    task automatic trama(input logic [7:0] q[$], input int huecos[$], input string nom);
        int         st[$];
        int         s, n;
        logic [7:0] x;
        logic [31:0] d;
        logic       ok;
        capt.delete();
        foreach (q[i]) begin
            enviar(q[i], huecos[i], s);
            st.push_back(s);
        end
        n = int'({q[1], q[2]});
        if (n > (1 << ADDR_W)) begin
            comprobar({nom, "_nesc"}, capt.size(), 0);
            comprobar({nom, "_error"}, error, 1);
            comprobar({nom, "_codigo"}, codigo_error, 2'b01);
            comprobar({nom, "_detener"}, cpu_detener, 1);
            comprobar({nom, "_lista"}, carga_lista, 0);
            comprobar({nom, "_palabras"}, palabras, 0);
        end else begin
            x = 8'h00;
            for (int w = 0; w < n; w++)
                for (int k = 0; k < 4; k++) x ^= q[3 + 4*w + k];
            ok = (q[q.size()-1] == x);
            comprobar({nom, "_nesc"}, capt.size(), n);
            for (int w = 0; w < n && w < capt.size(); w++) begin
                d = {q[3+4*w], q[4+4*w], q[5+4*w], q[6+4*w]};
                comprobar({nom, "_dir"}, capt[w].dir, w);
                comprobar({nom, "_dato"}, capt[w].dato, d);
                comprobar({nom, "_ciclo"}, capt[w].stamp, st[6 + 4*w]);
            end
            comprobar({nom, "_lista"}, carga_lista, ok);
            comprobar({nom, "_error"}, error, !ok);
            comprobar({nom, "_codigo"}, codigo_error, ok ? 2'b00 : 2'b10);
            comprobar({nom, "_detener"}, cpu_detener, !ok);
            comprobar({nom, "_palabras"}, palabras, n);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        int         h[$];
        int         s, n;
        logic [7:0] b;

        reset = 1'b1;
        bus.rx_valido = 1'b0;
        bus.rx_dato   = 8'h00;
        #2;
        comprobar("rst_detener", cpu_detener, 0);
        comprobar("rst_lista", carga_lista, 0);
        comprobar("rst_error", error, 0);
        comprobar("rst_codigo", codigo_error, 0);
        comprobar("rst_palabras", palabras, 0);
        comprobar("rst_escribir", bus.mem_escribir, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        q = {8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h66};
        huecos_rand(q.size(), 0, h);
        trama(q, h, "basica");
        q[q.size()-1] = 8'h67;
        trama(q, h, "chk_mal");

        q = {8'hA5, 8'h04, 8'h01};
        huecos_rand(q.size(), 2, h);
        trama(q, h, "long_mal");

        generar(1 << ADDR_W, 1'b0, q);
        huecos_rand(q.size(), 0, h);
        trama(q, h, "long_max");

        // Timeout: 14 idle cycles are tolerated, the 15th trips it.
        capt.delete();
        q = {8'hA5, 8'h00, 8'h01, 8'hAA};
        foreach (q[i]) enviar(q[i], 0, s);
        repeat (TO - 2) begin @(posedge clk); #1; end
        comprobar("to_antes", error, 0);
        @(posedge clk); #1;
        comprobar("to_error", error, 1);
        comprobar("to_codigo", codigo_error, 2'b11);
        comprobar("to_detener", cpu_detener, 1);
        comprobar("to_nesc", capt.size(), 0);

        q = {8'hA5, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        h = {0, 0, 0, 0, TO - 2, 0, 0, 0};
        trama(q, h, "to_limite");

        q = {8'hA5, 8'h00, 8'h01, 8'hA5, 8'h00, 8'h00, 8'h01, 8'hA4};
        huecos_rand(q.size(), 0, h);
        trama(q, h, "seguidos");
        enviar(8'hA5, 0, s);
        comprobar("recarga_lista", carga_lista, 0);
        comprobar("recarga_detener", cpu_detener, 1);
        q = {8'h00, 8'h00, 8'h00};
        foreach (q[i]) enviar(q[i], 0, s);
        comprobar("vacia_lista", carga_lista, 1);
        comprobar("vacia_detener", cpu_detener, 0);

        // Asynchronous reset on the 2nd byte of word 1.
        capt.delete();
        q = {8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        foreach (q[i]) enviar(q[i], 0, s);
        reset = 1'b1;
        #1;
        comprobar("rstm_detener", cpu_detener, 0);
        comprobar("rstm_palabras", palabras, 0);
        comprobar("rstm_error", error, 0);
        comprobar("rstm_codigo", codigo_error, 0);
        comprobar("rstm_dato", bus.mem_dato, 0);
        comprobar("rstm_nesc", capt.size(), 1);
        if (capt.size() > 0) comprobar("rstm_w0", capt[0].dato, 32'h11223344);
        #1;
        reset = 1'b0;
        q = {8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h66};
        huecos_rand(q.size(), 1, h);
        trama(q, h, "post_rst");

        for (int t = 0; t < 30; t++) begin
            repeat ($urandom_range(2, 0)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                enviar(b, int'($urandom_range(2, 0)), s);
            end
            if ($urandom_range(9, 0) == 0) n = int'($urandom_range(65535, 1025));
            else                           n = int'($urandom_range(6, 0));
            generar(n, $urandom_range(3, 0) == 0, q);
            huecos_rand(q.size(), 3, h);
            trama(q, h, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errores, checks);
        $finish;
    end
endmodule
